// File: rtl/drum_pkg.sv
// Shared drum-machine definitions: mode encoding, pattern geometry, index types.
package drum_pkg;

  typedef enum logic [1:0] {
    MODE_EDIT  = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_PAUSE = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam int unsigned NUM_STEPS = 8;
  localparam int unsigned NUM_SMPL  = 4;

  typedef logic [$clog2(NUM_STEPS)-1:0] step_t;
  typedef logic [$clog2(NUM_SMPL)-1:0]  smpl_t;
  typedef logic [NUM_SMPL-1:0]          row_t;

  // Index of the lowest set bit; 0 for an empty row.
  function automatic smpl_t lowest_set(input row_t r);
    smpl_t idx;
    idx = '0;
    for (int unsigned i = NUM_SMPL; i > 0; i--) begin
      if (r[i-1]) idx = smpl_t'(i-1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step tempo counter: pulses tick at each step boundary while running.
module step_tick_gen #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] step_period,
  output logic                tick
);

  logic [PERIOD_W-1:0] tick_cnt;
  logic [PERIOD_W-1:0] last_cnt;

  // A zero period behaves as one cycle per step.
  always_comb begin
    last_cnt = (step_period == '0) ? '0 : step_period - PERIOD_W'(1);
    tick     = run && (restart || (tick_cnt == last_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!run || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Pattern playback: steps through 8 rows and issues each set sample as a trigger.
module step_scheduler
  import drum_pkg::*;
#(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic [3:0]          seq_smpl_1,
  input  logic [3:0]          seq_smpl_2,
  input  logic [3:0]          seq_smpl_3,
  input  logic [3:0]          seq_smpl_4,
  input  logic [3:0]          seq_smpl_5,
  input  logic [3:0]          seq_smpl_6,
  input  logic [3:0]          seq_smpl_7,
  input  logic [3:0]          seq_smpl_8,
  output logic [2:0]          cur_step,
  output logic                step_strobe,
  output logic                trig_valid,
  output logic [1:0]          trig_smpl,
  input  logic                trig_ready,
  output logic                overrun
);

  mode_e mode_cur;
  mode_e prev_mode;
  logic  play;
  logic  restart;
  logic  tick;
  logic  handshake;
  step_t next_step;
  row_t  next_row;
  row_t  pending;
  row_t  accept_mask;

  always_comb begin
    mode_cur    = mode_e'(mode);
    play        = (mode_cur == MODE_PLAY);
    restart     = play && (prev_mode == MODE_EDIT);
    next_step   = restart ? '0 : cur_step + step_t'(1);
    handshake   = trig_valid && trig_ready;
    accept_mask = handshake ? (row_t'(1) << trig_smpl) : '0;
    case (next_step)
      3'd0:    next_row = seq_smpl_1;
      3'd1:    next_row = seq_smpl_2;
      3'd2:    next_row = seq_smpl_3;
      3'd3:    next_row = seq_smpl_4;
      3'd4:    next_row = seq_smpl_5;
      3'd5:    next_row = seq_smpl_6;
      3'd6:    next_row = seq_smpl_7;
      default: next_row = seq_smpl_8;
    endcase
  end

  assign trig_valid = |pending;
  assign trig_smpl  = lowest_set(pending);

  step_tick_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .run         (play),
    .restart     (restart),
    .step_period (step_period),
    .tick        (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_mode   <= MODE_EDIT;
      cur_step    <= '0;
      pending     <= '0;
      step_strobe <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      prev_mode   <= mode_cur;
      step_strobe <= tick;
      overrun     <= 1'b0;
      if (!play) begin
        pending <= '0;
        if (mode_cur == MODE_EDIT) cur_step <= '0;
      end else if (tick) begin
        // A trigger accepted on the boundary edge is delivered, not dropped.
        cur_step <= next_step;
        pending  <= next_row;
        overrun  <= |(pending & ~accept_mask);
      end else begin
        pending <= pending & ~accept_mask;
      end
    end
  end

endmodule
